ov7670_capture: RTL and testbench

Downstream neighbour of the OV7670 controller. Once `start_capture` is asserted, it samples the camera's parallel pixel bus (PCLK, VSYNC, HREF, D[7:0]) in the core clock domain. It assembles byte pairs into RGB565 pixels and emits one write strobe per pixel, with a linear frame-buffer address. It also reports frame completion and line-length errors to the frame-buffer writer.

---
 rtl/ov7670_capture.sv | 168 ++++++++++++++++
 tb/tb_ov7670_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: syncs PCLK/VSYNC/HREF/D into clk, packs byte pairs into RGB565 pixels.
// Define OV7670_CAPTURE_FRAME_CNT_EN to add the frame_cnt / err_cnt status counters.
`timescale 1ns/1ps
module ov7670_capture #(
   parameter int unsigned H_PIXELS = 640,
   parameter int unsigned V_LINES  = 480,
   parameter int unsigned ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_capture,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_d,
   output logic [15:0]       pix_data,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              pix_valid,
   output logic              frame_done,
   output logic              line_err,
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic [7:0]        err_cnt
`else
   output logic              busy
`endif
);

   localparam int unsigned CW = $clog2(H_PIXELS + 2);
   localparam int unsigned LW = $clog2(V_LINES + 2);
   localparam logic [CW-1:0]     COL_FULL  = CW'(H_PIXELS);
   localparam logic [CW-1:0]     COL_SAT   = '1;
   localparam logic [LW-1:0]     LINE_FULL = LW'(V_LINES);
   localparam logic [LW-1:0]     LINE_SAT  = '1;
   localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(H_PIXELS * V_LINES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_VS_HIGH,
      ST_WAIT_VS_FALL,
      ST_CAPTURE,
      ST_END
   } state_t;

   state_t state, state_next;

   logic pclk_s1, pclk_s2, pclk_s3;
   logic vsync_s1, vsync_s2, vsync_d;
   logic href_s1, href_s2, href_d;
   logic [7:0] d_s1, d_s2;

   logic              phase;
   logic [7:0]        hi_byte;
   logic [CW-1:0]     col_cnt;
   logic [LW-1:0]     line_cnt;
   logic [ADDR_W-1:0] pix_cnt;

   logic pclk_rise, vs_rise, vs_fall, href_fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3 <= 1'b0;
         vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_d <= 1'b0;
         href_s1  <= 1'b0; href_s2  <= 1'b0; href_d  <= 1'b0;
         d_s1     <= '0;   d_s2     <= '0;
      end else begin
         pclk_s1  <= cam_pclk;  pclk_s2  <= pclk_s1;  pclk_s3 <= pclk_s2;
         vsync_s1 <= cam_vsync; vsync_s2 <= vsync_s1; vsync_d <= vsync_s2;
         href_s1  <= cam_href;  href_s2  <= href_s1;  href_d  <= href_s2;
         d_s1     <= cam_d;     d_s2     <= d_s1;
      end
   end

   assign pclk_rise = pclk_s2 & ~pclk_s3;
   assign vs_rise   = vsync_s2 & ~vsync_d;
   assign vs_fall   = ~vsync_s2 & vsync_d;
   assign href_fall = ~href_s2 & href_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // ST_END holds frame_done off by one cycle so a pixel finishing with vsync rise is written first.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:         if (start_capture) state_next = ST_WAIT_VS_HIGH;
         ST_WAIT_VS_HIGH: if (vsync_s2)      state_next = ST_WAIT_VS_FALL;
         ST_WAIT_VS_FALL: if (vs_fall)       state_next = ST_CAPTURE;
         ST_CAPTURE:      if (vs_rise)       state_next = ST_END;
         ST_END:                             state_next = ST_WAIT_VS_FALL;
         default:                            state_next = ST_IDLE;
      endcase
      if (!start_capture) state_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_data   <= '0;
         pix_addr   <= '0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
         phase      <= 1'b0;
         hi_byte    <= '0;
         col_cnt    <= '0;
         line_cnt   <= '0;
         pix_cnt    <= '0;
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
         frame_cnt  <= '0;
         err_cnt    <= '0;
`endif
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (start_capture) begin
            case (state)
               ST_WAIT_VS_FALL: begin
                  if (vs_fall) begin
                     pix_cnt  <= '0;
                     col_cnt  <= '0;
                     line_cnt <= '0;
                     phase    <= 1'b0;
                     line_err <= 1'b0;
                  end
               end
               ST_CAPTURE: begin
                  if (pclk_rise && href_s2) begin
                     if (!phase) begin
                        hi_byte <= d_s2;
                        phase   <= 1'b1;
                     end else begin
                        phase <= 1'b0;
                        if (col_cnt != COL_SAT) col_cnt <= col_cnt + 1'b1;
                        if (col_cnt < COL_FULL && line_cnt < LINE_FULL) begin
                           pix_valid <= 1'b1;
                           pix_data  <= {hi_byte, d_s2};
                           pix_addr  <= pix_cnt;
                           if (pix_cnt != PIX_LAST) pix_cnt <= pix_cnt + 1'b1;
                        end
                     end
                  end
                  // a dangling high byte at line end is discarded
                  if (href_fall) begin
                     col_cnt <= '0;
                     phase   <= 1'b0;
                     if (line_cnt != LINE_SAT) line_cnt <= line_cnt + 1'b1;
                     if (phase || col_cnt != COL_FULL) line_err <= 1'b1;
                  end
               end
               ST_END: begin
                  frame_done <= 1'b1;
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
                  frame_cnt <= frame_cnt + 1'b1;
                  if (line_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign busy = (state == ST_CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized bench for ov7670_capture: camera model drives frames, a scoreboard checks pixels and frame ends.
`timescale 1ns/1ps
module tb_ov7670_capture;
   localparam int unsigned H  = 8;
   localparam int unsigned V  = 6;
   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_capture = 1'b0;
   logic          cam_pclk = 1'b0;
   logic          cam_vsync = 1'b1;
   logic          cam_href = 1'b0;
   logic [7:0]    cam_d = '0;
   logic [15:0]   pix_data;
   logic [AW-1:0] pix_addr;
   logic          pix_valid, frame_done, line_err, busy;
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
   logic [7:0]    err_cnt;
`endif

   ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start_capture(start_capture),
      .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
      .pix_data(pix_data), .pix_addr(pix_addr), .pix_valid(pix_valid),
      .frame_done(frame_done), .line_err(line_err),
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
      .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`else
      .busy(busy)
`endif
   );

   always #5 clk = ~clk;
   always #23 cam_pclk = ~cam_pclk;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] exp_addr[$];
   logic [15:0]   exp_data[$];
   logic          exp_err[$];
   int            model_frames = 0;
   int            model_errs = 0;

   int            line_bytes[16];
   logic [7:0]    fb[16][24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   logic [AW-1:0] m_addr;
   logic [15:0]   m_data;
   logic          m_err;

   always @(negedge clk) begin
      if (reset_n) begin
         if (pix_valid || frame_done)
            check("valid_done_exclusive", 32'(pix_valid & frame_done), 32'd0);
         if (pix_valid) begin
            if (exp_addr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pixel: got addr %0d data %0h, none expected", pix_addr, pix_data);
            end else begin
               m_addr = exp_addr.pop_front();
               m_data = exp_data.pop_front();
               check("pix_addr", 32'(pix_addr), 32'(m_addr));
               check("pix_data", 32'(pix_data), 32'(m_data));
            end
         end
         if (frame_done) begin
            if (exp_err.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_frame_done: got pulse, none expected");
            end else begin
               m_err = exp_err.pop_front();
               check("line_err_at_frame_done", 32'(line_err), 32'(m_err));
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check({tag, "_line_err"}, 32'(line_err), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
      check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
   endtask

   // kind: 0 none, 1 drop start_capture, 2 assert reset, 3 raise start_capture (join) -- at href rise of cut_line
   task automatic send_frame(input int nlines, input bit capture, input int cut_line, input int kind);
      int addr = 0;
      bit err = 1'b0;
      int npix;
      for (int l = 0; l < nlines; l++)
         for (int b = 0; b < line_bytes[l]; b++)
            fb[l][b] = 8'($urandom);
      if (capture) begin
         for (int l = 0; l < nlines; l++) begin
            npix = line_bytes[l] / 2;
            if ((line_bytes[l] % 2) != 0 || npix != int'(H)) err = 1'b1;
            if (l < int'(V) && l < cut_line)
               for (int p = 0; p < npix && p < int'(H); p++) begin
                  exp_addr.push_back(AW'(addr));
                  exp_data.push_back({fb[l][2*p], fb[l][2*p+1]});
                  addr++;
               end
         end
         if (kind == 0) begin
            exp_err.push_back(err);
            model_frames++;
            if (err) model_errs++;
         end
      end
      cam_vsync = 1'b0;
      repeat (2) @(negedge cam_pclk);
      for (int l = 0; l < nlines; l++) begin
         if (l == cut_line) begin
            case (kind)
               1: begin
                  start_capture = 1'b0;
                  fork begin repeat (10) @(posedge clk); start_capture = 1'b1; end join_none
               end
               2: begin
                  reset_n = 1'b0;
                  #2 check_reset_outputs("midframe_reset");
                  model_frames = 0;
                  model_errs = 0;
                  fork begin repeat (3) @(posedge clk); #1 reset_n = 1'b1; end join_none
               end
               3: start_capture = 1'b1;
               default: ;
            endcase
         end
         cam_href = 1'b1;
         for (int b = 0; b < line_bytes[l]; b++) begin
            cam_d = fb[l][b];
            if (l == 0 && b == 4) begin
               #2 check("busy_in_frame", 32'(busy), 32'(capture));
            end
            @(negedge cam_pclk);
         end
         cam_href = 1'b0;
         cam_d = '0;
         repeat (3) @(negedge cam_pclk);
      end
      cam_vsync = 1'b1;
      repeat (5) @(negedge cam_pclk);
   endtask

   task automatic set_lines_nominal();
      for (int l = 0; l < 16; l++) line_bytes[l] = 2 * int'(H);
   endtask

   task automatic check_counters();
`ifdef OV7670_CAPTURE_FRAME_CNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'(model_frames));
      check("err_cnt", 32'(err_cnt), 32'(model_errs > 255 ? 255 : model_errs));
`endif
   endtask

   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #2 check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge cam_pclk);

      // join mid-frame: this frame must be ignored entirely
      set_lines_nominal();
      send_frame(V, 1'b0, 2, 3);

      set_lines_nominal();
      send_frame(V, 1'b1, 99, 0);

      // long first line, odd-length second line
      set_lines_nominal();
      line_bytes[0] = 2 * int'(H) + 4;
      line_bytes[1] = 2 * int'(H) - 1;
      send_frame(V, 1'b1, 99, 0);

      // extra lines past V_LINES
      set_lines_nominal();
      send_frame(V + 2, 1'b1, 99, 0);
      check_counters();

      // abort mid-frame, re-arm shortly after
      set_lines_nominal();
      send_frame(V, 1'b1, 3, 1);

      set_lines_nominal();
      send_frame(V, 1'b1, 99, 0);
      check_counters();

      // asynchronous reset mid-frame
      set_lines_nominal();
      send_frame(V, 1'b1, 2, 2);

      set_lines_nominal();
      line_bytes[4] = 2 * int'(H) - 2;
      send_frame(V, 1'b1, 99, 0);
      check_counters();

      set_lines_nominal();
      send_frame(V, 1'b1, 99, 0);
      check_counters();

      repeat (20) @(posedge clk);
      check("leftover_pixels", 32'(exp_addr.size()), 32'd0);
      check("leftover_frames", 32'(exp_err.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
